// File: rtl/clkgen_multi.sv
// clkgen_multi: N-channel programmable integer clock divider / phase generator.
// Everything runs on refclk. Each channel owns a counter that runs 0..div-1 and
// produces a registered divided clock (high for ceil(div/2) counts), a
// one-cycle enable at count 0, and a shared channel reset derived from lock.
// A single config write port reprograms one channel at a time; the new
// divide/phase is held in a shadow and applied only at that channel's period
// boundary, so no runt pulses appear on clk_out.
//
// Ports:
//   refclk            system clock, rising edge
//   reset             synchronous, active-high
//   cfg_we            config write strobe
//   cfg_ch            target channel of the write
//   cfg_div/cfg_phase new divide value / phase offset (refclk cycles)
//   cfg_busy          a write is waiting for its period boundary
//   cfg_err           one-cycle pulse after a rejected write
//   clk_out[NUM_CH]   registered divided clocks
//   clk_en[NUM_CH]    one pulse per output period
//   rst_out[NUM_CH]   high while not locked
//   locked            all channels stable for LOCK_CYCLES cycles

// Per-channel divider. The enable/clock outputs are registered from the
// next-state count so they line up with the cycle in which cnt holds that value.
module clkgen_ch #(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic [DIV_W-1:0] init_div_i,
  input  logic [DIV_W-1:0] init_phase_i,
  input  logic             apply_i,
  input  logic [DIV_W-1:0] new_div_i,
  input  logic [DIV_W-1:0] new_phase_i,
  output logic             wrap_o,
  output logic             clk_out_o,
  output logic             clk_en_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             out_q, out_d;
  logic             en_q, en_d;
  logic [DIV_W:0]   half;

  // Phase is clamped to div-1; a nonzero phase p preloads div-p so the
  // first enable lands p cycles after the load cycle.
  function automatic logic [DIV_W-1:0] load_val(input logic [DIV_W-1:0] d,
                                                input logic [DIV_W-1:0] p);
    logic [DIV_W-1:0] pc;
    pc = (p >= d) ? d - DIV_W'(1) : p;
    return (pc == '0) ? '0 : d - pc;
  endfunction

  assign wrap_o = (cnt_q >= div_q - DIV_W'(1));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (!run_q) begin
      // first cycle out of reset: publish the preloaded count unchanged
      cnt_d = cnt_q;
    end else if (apply_i) begin
      div_d = new_div_i;
      cnt_d = load_val(new_div_i, new_phase_i);
    end else if (wrap_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    half  = ({1'b0, div_d} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    out_d = ({1'b0, cnt_d} < half);
    en_d  = (cnt_d == '0);
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      div_q <= init_div_i;
      cnt_q <= load_val(init_div_i, init_phase_i);
      run_q <= 1'b0;
      out_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      run_q <= 1'b1;
      out_q <= out_d;
      en_q  <= en_d;
    end
  end

  assign clk_out_o = out_q;
  assign clk_en_o  = en_q;

endmodule

module clkgen_multi #(
  parameter int                        NUM_CH      = 2,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT    = {8'd42, 8'd40},
  parameter logic [NUM_CH*DIV_W-1:0]   PHASE_INIT  = {8'd0, 8'd0},
  parameter int                        LOCK_CYCLES = 16,
  localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] rst_out,
  output logic              locked
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);

  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic [LCW-1:0]    lcnt_q, lcnt_d;
  logic [CH_W-1:0]   sh_ch_q;
  logic [DIV_W-1:0]  sh_div_q, sh_phase_q;

  logic [NUM_CH-1:0] wrap, apply;
  logic              ch_ok, accept, apply_any;

  clkgen_ch #(.DIV_W(DIV_W)) u_ch [NUM_CH-1:0] (
    .refclk       (refclk),
    .reset        (reset),
    .init_div_i   (DIV_INIT),
    .init_phase_i (PHASE_INIT),
    .apply_i      (apply),
    .new_div_i    (sh_div_q),
    .new_phase_i  (sh_phase_q),
    .wrap_o       (wrap),
    .clk_out_o    (clk_out),
    .clk_en_o     (clk_en)
  );

  // Only the shadow's target channel applies, on its own last count; other
  // channels wrapping in the same cycle are untouched.
  always_comb begin
    apply = '0;
    for (int i = 0; i < NUM_CH; i++)
      apply[i] = busy_q && (sh_ch_q == CH_W'(i)) && wrap[i];
  end

  assign apply_any = |apply;
  assign ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  assign accept    = cfg_we && !busy_q && (cfg_div != '0) && ch_ok;

  always_comb begin
    err_d  = cfg_we && !accept;
    busy_d = busy_q;
    if (accept)         busy_d = 1'b1;
    else if (apply_any) busy_d = 1'b0;

    // Lock count restarts on accept/apply, idles while a write is pending,
    // and saturates at LOCK_CYCLES.
    lcnt_d = lcnt_q;
    if (accept || apply_any)
      lcnt_d = '0;
    else if (!busy_q && (lcnt_q != LCW'(LOCK_CYCLES)))
      lcnt_d = lcnt_q + LCW'(1);

    locked_d = (lcnt_d == LCW'(LOCK_CYCLES)) && !busy_d;
    rst_d    = {NUM_CH{~locked_d}};
  end

  always_ff @(posedge refclk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      rst_q      <= '1;
      lcnt_q     <= '0;
      sh_ch_q    <= '0;
      sh_div_q   <= '0;
      sh_phase_q <= '0;
    end else begin
      busy_q   <= busy_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      rst_q    <= rst_d;
      lcnt_q   <= lcnt_d;
      if (accept) begin
        sh_ch_q    <= cfg_ch;
        sh_div_q   <= cfg_div;
        sh_phase_q <= cfg_phase;
      end
    end
  end

  assign cfg_busy = busy_q;
  assign cfg_err  = err_q;
  assign locked   = locked_q;
  assign rst_out  = rst_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi. A time-based reference model predicts every output
// each cycle: a channel loaded at edge t0 with divide d and phase p sits at
// position (t - t0 + d - p) mod d, enables at position 0 and is high for the
// first ceil(d/2) positions. A table of config writes is measured for first
// enable delay, period and high time; hand sequences cover rejects and reset
// during a pending write; a random phase exercises the model further.
module tb_clkgen_multi;
  localparam int NUM_CH = 2;
  localparam int DIV_W  = 8;
  localparam int LOCK   = 16;
  localparam int CH_W   = 1;

  logic              refclk = 1'b0;
  logic              reset  = 1'b1;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic              cfg_busy, cfg_err, locked;
  logic [NUM_CH-1:0] clk_out, clk_en, rst_out;

  clkgen_multi #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W),
    .DIV_INIT({8'd42, 8'd40}), .PHASE_INIT({8'd0, 8'd0}),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .refclk(refclk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_busy(cfg_busy),
    .cfg_err(cfg_err), .clk_out(clk_out), .clk_en(clk_en),
    .rst_out(rst_out), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int INIT_DIV [NUM_CH] = '{40, 42};
  int INIT_PH  [NUM_CH] = '{0, 0};
  int m_t, m_sync;
  int m_div [NUM_CH];
  int m_ph  [NUM_CH];
  int m_t0  [NUM_CH];
  bit m_busy, m_err;
  int m_sch, m_sdiv, m_sph;
  logic [NUM_CH-1:0] e_en, e_out, e_rst;
  logic e_lock, e_busy, e_err;

  // bench bookkeeping
  int cyc = 0;
  int last_en_t [NUM_CH] = '{-1000, -1000};
  int cur_div   [NUM_CH];

  typedef struct {
    int ch, dv, ph;
    int first, period, high;
  } vec_t;
  vec_t tbl [6];

  function automatic int clampf(int p, int d);
    return (p >= d) ? d - 1 : p;
  endfunction

  function automatic int pos(int c, int t);
    return (t - m_t0[c] + m_div[c] - m_ph[c]) % m_div[c];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit we, input int ch, input int dv, input int ph);
    bit busy_pre;
    int c;
    if (r) begin
      m_t = -1; m_sync = -1; m_busy = 0; m_err = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_div[k] = INIT_DIV[k];
        m_ph[k]  = clampf(INIT_PH[k], INIT_DIV[k]);
        m_t0[k]  = 0;
      end
      e_en = '0; e_out = '0; e_rst = '1; e_lock = 0; e_busy = 0; e_err = 0;
      return;
    end
    m_t++;
    busy_pre = m_busy;
    if (m_busy) begin
      c = m_sch;
      if (pos(c, m_t - 1) == m_div[c] - 1) begin
        m_div[c] = m_sdiv;
        m_ph[c]  = clampf(m_sph, m_sdiv);
        m_t0[c]  = m_t;
        m_busy   = 0;
        m_sync   = m_t;
      end
    end
    m_err = 0;
    if (we) begin
      if (!busy_pre && dv != 0 && ch < NUM_CH) begin
        m_busy = 1; m_sch = ch; m_sdiv = dv; m_sph = ph;
      end else m_err = 1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      e_en[k]  = (pos(k, m_t) == 0);
      e_out[k] = (pos(k, m_t) < (m_div[k] + 1) / 2);
    end
    e_busy = m_busy;
    e_err  = m_err;
    e_lock = !m_busy && (m_t - m_sync >= LOCK);
    e_rst  = e_lock ? '0 : '1;
  endtask

  task automatic tick(input bit r, input bit we, input int ch, input int dv, input int ph);
    reset     = r;
    cfg_we    = we;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    cfg_phase = DIV_W'(ph);
    @(posedge refclk);
    model_step(r, we, ch, dv, ph);
    #1;
    cyc++;
    for (int k = 0; k < NUM_CH; k++) if (clk_en[k] === 1'b1) last_en_t[k] = cyc;
    check("clk_en",   clk_en,   e_en);
    check("clk_out",  clk_out,  e_out);
    check("rst_out",  rst_out,  e_rst);
    check("locked",   locked,   e_lock);
    check("cfg_busy", cfg_busy, e_busy);
    check("cfg_err",  cfg_err,  e_err);
  endtask

  // Reset (n_rst cycles), then check the default periods and the lock timing.
  task automatic chk_defaults(input int n_rst);
    int e0[$];
    int e1[$];
    logic o0 [50];
    int lk_rise, hi;
    for (int k = 0; k < n_rst; k++) tick(1, 0, 0, 0, 0);
    check("rst_clk_out", clk_out, '0);
    check("rst_clk_en",  clk_en,  '0);
    check("rst_rst_out", rst_out, {NUM_CH{1'b1}});
    check("rst_locked",  locked,  0);
    check("rst_busy",    cfg_busy, 0);
    check("rst_err",     cfg_err, 0);
    lk_rise = -1;
    for (int j = 0; j < 50; j++) begin
      tick(0, 0, 0, 0, 0);
      if (clk_en[0]) e0.push_back(j);
      if (clk_en[1]) e1.push_back(j);
      o0[j] = clk_out[0];
      if (locked && lk_rise < 0) lk_rise = j;
    end
    // 16th edge after the last reset edge is index 15
    check("lock_rise_cycle", lk_rise, 15);
    if (e0.size() >= 2 && e1.size() >= 2) begin
      check("ch0_first_en", e0[0], 0);
      check("ch0_period", e0[1] - e0[0], 40);
      hi = 0;
      for (int j = e0[0]; j < e0[1]; j++) hi += int'(o0[j]);
      check("ch0_high", hi, 20);
      check("ch1_period", e1[1] - e1[0], 42);
    end else begin
      check("default_en_pulses", e0.size() + e1.size(), 4);
    end
    cur_div[0] = 40;
    cur_div[1] = 42;
  endtask

  task automatic run_vec(input vec_t v);
    int prev, budget, first, second, hi, n;
    logic en_h [64];
    logic out_h [64];
    logic lk_h [64];
    tick(0, 1, v.ch, v.dv, v.ph);
    check("wr_busy", cfg_busy, 1);
    check("wr_locked", locked, 0);
    prev = last_en_t[v.ch];
    budget = 0;
    while (cfg_busy && budget < 600) begin
      prev = last_en_t[v.ch];
      tick(0, 0, 0, 0, 0);
      budget++;
    end
    if (cfg_busy) begin
      check("apply_timeout", cfg_busy, 0);
      return;
    end
    check("old_period_intact", cyc - prev, cur_div[v.ch]);
    n = v.ph + 2 * v.dv + 2;
    if (n < 17) n = 17;
    for (int j = 0; j < n; j++) begin
      if (j > 0) tick(0, 0, 0, 0, 0);
      en_h[j]  = clk_en[v.ch];
      out_h[j] = clk_out[v.ch];
      lk_h[j]  = locked;
    end
    first = -1; second = -1;
    for (int j = 0; j < n; j++)
      if (en_h[j]) begin
        if (first < 0) first = j;
        else if (second < 0) second = j;
      end
    check("first_en_delay", first, v.first);
    check("period", second - first, v.period);
    hi = 0;
    if (first >= 0 && second > first)
      for (int j = first; j < second; j++) hi += int'(out_h[j]);
    check("high_time", hi, v.high);
    check("lock_apply_plus15", lk_h[15], 0);
    check("lock_apply_plus16", lk_h[16], 1);
    cur_div[v.ch] = v.dv;
  endtask

  initial begin
    int budget;
    //          ch dv ph  first period high
    tbl[0] = '{0,  5, 0,  0,  5,  3};
    tbl[1] = '{1, 10, 3,  3, 10,  5};
    tbl[2] = '{0,  1, 0,  0,  1,  1};
    tbl[3] = '{1,  4, 7,  3,  4,  2};   // phase clamped to 3
    tbl[4] = '{0,  7, 2,  2,  7,  4};
    tbl[5] = '{1,  2, 1,  1,  2,  1};

    chk_defaults(3);
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // rejected writes: div=0, then a write while busy
    tick(0, 1, 0, 0, 5);
    check("rej_div0_err", cfg_err, 1);
    check("rej_div0_busy", cfg_busy, 0);
    tick(0, 0, 0, 0, 0);
    check("rej_err_one_cycle", cfg_err, 0);
    tick(0, 1, 1, 6, 0);
    tick(0, 1, 0, 9, 0);
    check("rej_busy_err", cfg_err, 1);
    tick(0, 0, 0, 0, 0);
    check("rej_busy_err_clear", cfg_err, 0);
    budget = 0;
    while (cfg_busy && budget < 100) begin tick(0, 0, 0, 0, 0); budget++; end
    check("rej_apply_done", cfg_busy, 0);
    for (int j = 0; j < 20; j++) tick(0, 0, 0, 0, 0);

    // reset while a write is pending discards it
    tick(0, 1, 0, 30, 0);
    check("pend_busy", cfg_busy, 1);
    chk_defaults(2);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, NUM_CH - 1), $urandom_range(0, 12), $urandom_range(0, 15));
    tick(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/clkgen_multi.md
Name: clkgen_multi

Overview:
- Parametrised successor to the fixed two-output clock block: N-channel programmable integer divider and phase generator in the refclk domain.
- Per channel, produces a registered divided clock, a one-cycle clock-enable pulse and a channel reset.
- Adds a lock indicator and runtime reprogramming through a simple config write port.
- Reprogramming is glitch-free: new settings apply only on a period boundary.
- Feeds fabric logic needing slower synchronous enables, e.g. pixel, sampling and LED scan rates.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- DIV_W, 8, width of divide and phase values.
- DIV_INIT, {8'd42,8'd40}, packed NUM_CH×DIV_W reset divide values; channel 0 is in the LSBs.
- PHASE_INIT, {8'd0,8'd0}, packed NUM_CH×DIV_W reset phase offsets, in refclk cycles.
- LOCK_CYCLES, 16, stable cycles required before locked asserts (≥1).

Ports:
- refclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe, sampled each cycle.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  DIV_W  new divide value.
- cfg_phase  in  DIV_W  new phase offset.
- cfg_busy  out  1  a write is pending application.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- clk_out  out  NUM_CH  registered divided clocks.
- clk_en  out  NUM_CH  one-cycle pulse per output period.
- rst_out  out  NUM_CH  per-channel reset, high while not locked.
- locked  out  1  all channels stable.

Behaviour:
- Reset values: clk_out=0, clk_en=0, rst_out=all 1, locked=0, cfg_busy=0, cfg_err=0.
- Reset also loads each channel's div/phase from DIV_INIT/PHASE_INIT and clears the lock counter.
- A reset asserted mid-operation aborts any pending write; the write is discarded.

Per-channel counter:
- cnt runs 0..div-1 and wraps to 0.
- clk_en[i]=1 in the cycle where cnt==0.
- clk_out[i]=1 while cnt < ceil(div/2): for odd div, the high time is one cycle longer.
- div=1: clk_out held at 1 and clk_en pulses every cycle.

Phase:
- On load (leaving reset, or applying a write), cnt is loaded with (phase==0) ? 0 : div-phase.
- Result: the first clk_en occurs phase cycles after the load cycle.
- phase ≥ div is clamped to div-1.
- Channels with equal phase have coincident clk_en.

Config write (accepted when cfg_we=1, cfg_busy=0, cfg_div≠0 and cfg_ch<NUM_CH):
- The cycle after the write, cfg_busy=1 and locked=0.
- The value is held in a shadow register.
- It is applied on the target channel's cycle where cnt==div-1 (old div); the next cycle loads the new phase value.
- The current period always completes, so there are no runt pulses.
- cfg_busy falls in the apply cycle.

Rejected write (cfg_busy=1, cfg_div=0, or cfg_ch out of range):
- cfg_err pulses for one cycle, the cycle after the write.
- No state changes.

Lock:
- The lock counter restarts at 0 on reset release and on each apply.
- It increments while no write is pending.
- locked rises when the counter reaches LOCK_CYCLES, then holds (the counter saturates).
- rst_out[i] = ~locked, registered, with the same timing as locked.
- When locked drops on a write accept, all rst_out reassert (global re-sync).

Simultaneous events:
- reset has priority over everything.
- A write accepted in the same cycle as another channel's wrap has no effect on that other channel.

Test Plan:
- Reset release with defaults → ch0 clk_en period is 40 and ch1's is 42; clk_out0 is high for 20 cycles; locked=1 and rst_out=00 exactly 16 cycles after release.
- Write ch0, div=5, phase=0, mid-period → cfg_busy until ch0 wraps; the old 40-cycle period completes intact; then ch0 has period 5 with clk_out high for 3 and low for 2; locked falls, then rises 16 cycles after apply.
- Write ch1, div=10, phase=3 → first ch1 clk_en is 3 cycles after the load cycle, then every 10 cycles.
- Write div=0, then a second write while cfg_busy=1 → cfg_err pulses once each; divides are unchanged.
- Write div=1 → clk_out held at 1 and clk_en every cycle; write phase=7 with div=4 → phase clamped to 3.
- reset asserted while a write is pending → after release, DIV_INIT values are restored, cfg_busy=0, and the lock sequence repeats.
